// File: rtl/result_fifo_pkg.sv
// Shared types and constants for the inverter result FIFO.
package result_fifo_pkg;

  localparam int DATA_W        = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef logic [DATA_W-1:0] word_t;

  // Pointer width for a given entry count; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// Register-array storage for the result FIFO: synchronous write port,
// combinational (show-ahead) read port. Contents are never reset.
module result_fifo_mem
  import result_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DATA_W,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming entry at the write address on an accepted push.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Head entry is presented without a register stage.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/result_fifo_32bit.sv
// Synchronous show-ahead FIFO holding 32-bit inverter results with a
// valid/ready handshake on both sides. Occupancy comes from a dedicated
// count register rather than pointer comparison.
// Optional feature macro: RESULT_FIFO_PARITY_EN (adds a stored even-parity
// bit per entry and the out_parity port).
module result_fifo_32bit
  import result_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = result_fifo_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef RESULT_FIFO_PARITY_EN
  ,output logic                    out_parity
`endif
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef RESULT_FIFO_PARITY_EN
  localparam int MEM_W = 32 + 1;
`else
  localparam int MEM_W = 32;
`endif

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("result_fifo_32bit: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;
  logic [MEM_W-1:0] wr_entry;
  logic [MEM_W-1:0] rd_entry;

  // Flags and handshakes derive from registered occupancy only.
  always_comb begin
    full      = (count_q == DEPTH_C);
    empty     = (count_q == '0);
    in_ready  = !full;
    out_valid = !empty;
    count     = count_q;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Build the stored entry; the parity bit rides above the data word.
  always_comb begin
`ifdef RESULT_FIFO_PARITY_EN
    wr_entry = {^in_data, in_data};
`else
    wr_entry = in_data;
`endif
  end

  // Pointer and occupancy tracking; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  result_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !rst),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // Split the head entry back into data and (optionally) parity.
  always_comb begin
    out_data = rd_entry[31:0];
`ifdef RESULT_FIFO_PARITY_EN
    out_parity = rd_entry[32];
`endif
  end

endmodule
